// File: rtl/armleosoc_simple2axi_converter.sv
// armleosoc_simple2axi_converter: bridges a single-outstanding simple request port onto one 32-bit AXI4 host.
// Every AXI transfer is a single beat; write wins over a simultaneous read.
module armleosoc_simple2axi_converter #(
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic write,
    input  logic read,
    input  logic [31:0] write_data,
    input  logic [3:0] write_byteenable,
    output logic ready,
    output logic done,
    output logic [31:0] read_data,
    output logic address_error,
    output logic access_error,
    output logic axi_awvalid,
    input  logic axi_awready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [ID_WIDTH-1:0] axi_awid,
    output logic [7:0] axi_awlen,
    output logic [2:0] axi_awsize,
    output logic [1:0] axi_awburst,
    output logic axi_awlock,
    output logic [3:0] axi_awcache,
    output logic [2:0] axi_awprot,
    output logic axi_wvalid,
    input  logic axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0] axi_wstrb,
    output logic axi_wlast,
    input  logic axi_bvalid,
    output logic axi_bready,
    input  logic [1:0] axi_bresp,
    input  logic [ID_WIDTH-1:0] axi_bid,
    output logic axi_arvalid,
    input  logic axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [ID_WIDTH-1:0] axi_arid,
    output logic [7:0] axi_arlen,
    output logic [2:0] axi_arsize,
    output logic [1:0] axi_arburst,
    output logic axi_arlock,
    output logic [3:0] axi_arcache,
    output logic [2:0] axi_arprot,
    input  logic axi_rvalid,
    output logic axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0] axi_rresp,
    input  logic axi_rlast,
    input  logic [ID_WIDTH-1:0] axi_rid
);

    typedef enum logic [2:0] {IDLE, WRITE_ADDR_DATA, WRITE_RESP, READ_ADDR, READ_RESP} state_t;

    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0] wbe_r;
    logic aw_done, w_done;
    logic aw_hs, w_hs;
    logic unused_ok;

    assign unused_ok = ^{axi_bid, axi_rid, axi_rlast};
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs = axi_wvalid && axi_wready;

    assign axi_awaddr = addr_r;
    assign axi_araddr = addr_r;
    assign axi_wdata = wdata_r;
    assign axi_wstrb = wbe_r;
    assign axi_awid = AXI_ID;
    assign axi_arid = AXI_ID;
    assign axi_awlen = 8'd0;
    assign axi_arlen = 8'd0;
    assign axi_awsize = 3'b010;
    assign axi_arsize = 3'b010;
    assign axi_awburst = 2'b01;
    assign axi_arburst = 2'b01;
    assign axi_awlock = 1'b0;
    assign axi_arlock = 1'b0;
    assign axi_awcache = 4'd0;
    assign axi_arcache = 4'd0;
    assign axi_awprot = 3'd0;
    assign axi_arprot = 3'd0;
    assign axi_wlast = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:            next_state = write ? WRITE_ADDR_DATA : read ? READ_ADDR : IDLE;
            WRITE_ADDR_DATA: next_state = ((aw_done || aw_hs) && (w_done || w_hs)) ? WRITE_RESP : WRITE_ADDR_DATA;
            WRITE_RESP:      next_state = axi_bvalid ? IDLE : WRITE_RESP;
            READ_ADDR:       next_state = axi_arready ? READ_RESP : READ_ADDR;
            READ_RESP:       next_state = axi_rvalid ? IDLE : READ_RESP;
            default:         next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = state == IDLE;
        axi_awvalid = state == WRITE_ADDR_DATA && !aw_done;
        axi_wvalid = state == WRITE_ADDR_DATA && !w_done;
        axi_bready = state == WRITE_RESP;
        axi_arvalid = state == READ_ADDR;
        axi_rready = state == READ_RESP;
    end

    // aw_done/w_done remember a finished half of the write so each valid drops independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            wdata_r <= '0;
            wbe_r <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            done <= 1'b0;
            read_data <= '0;
            address_error <= 1'b0;
            access_error <= 1'b0;
        end else begin
            aw_done <= state == WRITE_ADDR_DATA && (aw_done || aw_hs);
            w_done <= state == WRITE_ADDR_DATA && (w_done || w_hs);
            done <= (state == WRITE_RESP && axi_bvalid) || (state == READ_RESP && axi_rvalid);
            if (state == IDLE && (write || read))
                addr_r <= address;
            if (state == IDLE && write) begin
                wdata_r <= write_data;
                wbe_r <= write_byteenable;
            end
            if (state == WRITE_RESP && axi_bvalid) begin
                address_error <= axi_bresp == 2'b11;
                access_error <= axi_bresp == 2'b10;
            end
            if (state == READ_RESP && axi_rvalid) begin
                read_data <= axi_rdata;
                address_error <= axi_rresp == 2'b11;
                access_error <= axi_rresp == 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_armleosoc_simple2axi_converter.sv
// tb_armleosoc_simple2axi_converter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the bridge.
module tb_armleosoc_simple2axi_converter;

    logic clk, rst_n;
    logic [33:0] address;
    logic write, read;
    logic [31:0] write_data;
    logic [3:0] write_byteenable;
    logic ready, done, address_error, access_error;
    logic [31:0] read_data;
    logic axi_awvalid, axi_awready, axi_awlock, axi_arlock;
    logic [33:0] axi_awaddr, axi_araddr;
    logic [3:0] axi_awid, axi_arid, axi_bid, axi_rid, axi_awcache, axi_arcache, axi_wstrb;
    logic [7:0] axi_awlen, axi_arlen;
    logic [2:0] axi_awsize, axi_arsize, axi_awprot, axi_arprot;
    logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
    logic [31:0] axi_wdata, axi_rdata;

    armleosoc_simple2axi_converter dut (
        .clk(clk), .rst_n(rst_n), .address(address), .write(write), .read(read),
        .write_data(write_data), .write_byteenable(write_byteenable), .ready(ready), .done(done),
        .read_data(read_data), .address_error(address_error), .access_error(access_error),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arid(axi_arid),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rid(axi_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_done = 0, n_arv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding transaction, tracked by which handshakes it has completed
    logic m_busy = 0, m_wr = 0, m_aws = 0, m_ws = 0, m_ars = 0, m_done = 0, m_aerr = 0, m_serr = 0;
    logic [33:0] m_addr = 0;
    logic [31:0] m_data = 0, m_rd = 0;
    logic [3:0] m_be = 0;
    logic hs_b_f = 0, hs_r_f = 0;
    logic e_aw, e_w, e_b, e_ar, e_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rd = 0; hs_b_f = 0; hs_r_f = 0;
            chk("reset_outputs", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, done, address_error, access_error}, 8'h00);
            chk("reset_read_data", read_data, 32'h0);
        end else begin
            e_aw = m_busy && m_wr && !m_aws;
            e_w = m_busy && m_wr && !m_ws;
            e_b = m_busy && m_wr && m_aws && m_ws;
            e_ar = m_busy && !m_wr && !m_ars;
            e_r = m_busy && !m_wr && m_ars;
            chk("done", done, m_done);
            if (m_done) chk("error_flags", {address_error, access_error}, {m_aerr, m_serr});
            chk("ready", ready, !m_busy);
            chk("read_data", read_data, m_rd);
            chk("valids_readies", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, {e_aw, e_w, e_b, e_ar, e_r});
            if (e_aw) chk("awaddr", axi_awaddr, m_addr);
            if (e_w) chk("wdata_wstrb", {axi_wdata, axi_wstrb}, {m_data, m_be});
            if (e_ar) chk("araddr", axi_araddr, m_addr);
            chk("aw_const", {axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awid, axi_wlast},
                {8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 1'b1});
            chk("ar_const", {axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arid},
                {8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
            if (axi_arvalid) n_arv++;
            if (m_done) n_done++;
            hs_b_f = e_b && axi_bvalid;
            hs_r_f = e_r && axi_rvalid;
            m_done = 0;
            if (!m_busy) begin
                if (write || read) begin
                    m_busy = 1; m_wr = write; m_aws = 0; m_ws = 0; m_ars = 0;
                    m_addr = address; m_data = write_data; m_be = write_byteenable;
                end
            end else if (m_wr) begin
                if (e_aw && axi_awready) m_aws = 1;
                if (e_w && axi_wready) m_ws = 1;
                if (hs_b_f) begin
                    m_busy = 0; m_done = 1; m_aerr = axi_bresp == 2'b11; m_serr = axi_bresp == 2'b10;
                end
            end else begin
                if (e_ar && axi_arready) m_ars = 1;
                if (hs_r_f) begin
                    m_busy = 0; m_done = 1; m_rd = axi_rdata;
                    m_aerr = axi_rresp == 2'b11; m_serr = axi_rresp == 2'b10;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < start + 50);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within 50 cycles at %0t", $time);
        end
    endtask

    task automatic run_random(input int n, input bit req);
        for (int i = 0; i < n; i++) begin
            cyc();
            axi_awready = $urandom_range(0, 2) != 0;
            axi_wready = $urandom_range(0, 2) != 0;
            axi_arready = $urandom_range(0, 2) != 0;
            if (axi_bvalid) begin
                if (hs_b_f) axi_bvalid = 0;
            end else if (m_busy && m_wr && m_aws && m_ws && $urandom_range(0, 1) == 1) begin
                axi_bvalid = 1; axi_bresp = 2'($urandom); axi_bid = 4'($urandom);
            end
            if (axi_rvalid) begin
                if (hs_r_f) axi_rvalid = 0;
            end else if (m_busy && !m_wr && m_ars && $urandom_range(0, 1) == 1) begin
                axi_rvalid = 1; axi_rdata = $urandom; axi_rresp = 2'($urandom);
                axi_rid = 4'($urandom); axi_rlast = 1'($urandom);
            end
            write = req && $urandom_range(0, 3) == 0;
            read = req && $urandom_range(0, 2) == 0;
            address = {2'($urandom), 30'($urandom), 2'b00};
            write_data = $urandom;
            write_byteenable = 4'($urandom);
        end
    endtask

    task automatic slave_idle();
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
        axi_rvalid = 0; axi_rresp = 0; axi_rid = 0; axi_rlast = 0; axi_rdata = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, d0, a0;
        rst_n = 0; write = 0; read = 0; address = 0; write_data = 0; write_byteenable = 0;
        slave_idle();
        repeat (3) cyc();
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", ready, 1'b1);

        // single write with everything ready: AW/W at T+1, done at T+3
        cyc();
        axi_awready = 1; axi_wready = 1; axi_bvalid = 1; axi_bresp = 2'b00;
        write = 1; address = 34'h10; write_data = 32'hDEADBEEF; write_byteenable = 4'hF;
        cyc();
        write = 0;
        @(negedge clk);
        chk("t034_aw_w_valid", {axi_awvalid, axi_wvalid}, 2'b11);
        chk("t034_awaddr", axi_awaddr, 34'h10);
        chk("t034_wdata", axi_wdata, 32'hDEADBEEF);
        wait_done(1, lat);
        chk("t034_done_latency", lat, 3);
        chk("t034_no_errors", {address_error, access_error}, 2'b00);
        cyc();
        slave_idle();

        // W accepted three cycles after AW
        write = 1; address = 34'h14; write_data = 32'hDEADBEEF; write_byteenable = 4'h3; axi_awready = 1;
        cyc();
        write = 0;
        cyc();
        axi_awready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t035_w_held", {axi_awvalid, axi_wvalid, axi_wdata}, {1'b0, 1'b1, 32'hDEADBEEF});
        end
        cyc();
        axi_wready = 1; axi_bvalid = 1; axi_bresp = 2'b00;
        d0 = n_done;
        wait_done(0, lat);
        cyc();
        slave_idle();
        repeat (4) cyc();
        chk("t035_one_done", n_done - d0, 1);

        // read with DECERR after AR delay
        read = 1; address = 34'h20;
        axi_rvalid = 1; axi_rdata = 32'h12345678; axi_rresp = 2'b11;
        cyc();
        read = 0;
        cyc();
        cyc();
        axi_arready = 1;
        wait_done(0, lat);
        chk("t036_read_data", read_data, 32'h12345678);
        chk("t036_decerr", {address_error, access_error}, 2'b10);
        cyc();
        slave_idle();

        // simultaneous write and read: only the write runs
        a0 = n_arv;
        write = 1; read = 1; address = 34'h40; write_data = 32'hCAFEF00D; write_byteenable = 4'hF;
        axi_awready = 1; axi_wready = 1; axi_bvalid = 1; axi_bresp = 2'b10;
        cyc();
        write = 0; read = 0;
        wait_done(0, lat);
        chk("t037_slverr", {address_error, access_error}, 2'b01);
        chk("t037_read_data_kept", read_data, 32'h12345678);
        cyc();
        chk("t037_no_ar", n_arv - a0, 0);
        slave_idle();

        // read presented in the done cycle of a write
        axi_awready = 1; axi_wready = 1; axi_bvalid = 1; axi_bresp = 2'b00;
        write = 1; address = 34'h50; write_data = 32'h01020304;
        cyc();
        write = 0;
        cyc();
        cyc();
        read = 1; address = 34'h60; axi_arready = 1; axi_rvalid = 1; axi_rdata = 32'hA5A55A5A; axi_rresp = 2'b00;
        @(negedge clk);
        chk("t039_done_and_ready", {done, ready}, 2'b11);
        cyc();
        read = 0; axi_bvalid = 0;
        @(negedge clk);
        chk("t039_arvalid_next", axi_arvalid, 1'b1);
        wait_done(0, lat);
        chk("t039_read_data", read_data, 32'hA5A55A5A);
        cyc();
        slave_idle();

        // reset while AW is pending
        write = 1; address = 34'h70;
        cyc();
        write = 0;
        @(negedge clk);
        chk("t038_aw_pending", axi_awvalid, 1'b1);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t038_async_clear", {axi_awvalid, axi_wvalid, done}, 3'b000);
        cyc();
        cyc();
        rst_n = 1;
        d0 = n_done;
        @(negedge clk);
        chk("t038_ready_after_release", ready, 1'b1);
        repeat (5) cyc();
        chk("t038_no_done", n_done - d0, 0);

        // randomized traffic, then drain
        slave_idle();
        run_random(3000, 1'b1);
        run_random(20, 1'b0);
        for (int i = 0; i < 200 && m_busy; i++) run_random(1, 1'b0);
        if (m_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: transaction still outstanding after 200 cycles");
        end
        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
